manhattan_sequence_generator: RTL

Serial pattern transmitter that drives a programmable bit pattern, MSB-first, one bit per clock, into the sequence input of manhattan_sequencedetector. It supports a repeat count and an idle gap between repetitions. It is the stimulus or transmit end of the serial-sequence path, usable both in-system and as a loopback source for detector checks.

---
 rtl/manhattan_sequence_generator_pkg.sv | 19 +
 rtl/manhattan_sequence_generator_down_counter.sv | 29 ++
 rtl/manhattan_sequence_generator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/manhattan_sequence_generator_pkg.sv
// Shared types and constants for the Manhattan serial pattern transmitter.
// Holds the FSM state encoding, the power-up pattern and named test patterns.
package manhattan_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } seqState_e;

   localparam logic [7:0] DEFAULT_PATTERN = 8'b0011_0101;
   localparam int         DEFAULT_LEN     = 6;

   localparam logic [5:0] PAT_GOOD = 6'b110101;
   localparam logic [5:0] PAT_ALT  = 6'b101010;
   localparam logic [5:0] PAT_ONES = 6'b111111;

endpackage

// File: rtl/manhattan_sequence_generator_down_counter.sv
// Loadable down counter with a zero flag, used for the bit, repeat and gap
// counters of the pattern transmitter. Saturates at zero.
module manhattan_down_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] loadValue,
   input  logic         decrement,
   output logic [W-1:0] value,
   output logic         zero
);

   // Load has priority over decrement so a reload on the last count of a
   // frame starts the next frame without a bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= loadValue;
      end else if (decrement && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/manhattan_sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, one bit per
// clock, with a repeat count and an idle gap between repetitions.
module manhattan_sequence_generator #(
   parameter int               PAT_W           = 8,
   parameter int               LEN_W           = $clog2(PAT_W + 1),
   parameter int               REP_W           = 4,
   parameter int               GAP_W           = 4,
   parameter logic [PAT_W-1:0] DEFAULT_PATTERN = manhattan_seq_pkg::DEFAULT_PATTERN,
   parameter int               DEFAULT_LEN     = manhattan_seq_pkg::DEFAULT_LEN
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic [REP_W-1:0] rep_in,
   input  logic [GAP_W-1:0] gap_in,
   output logic             sequence_out,
   output logic             valid_out,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   import manhattan_seq_pkg::*;

   seqState_e state, stateNext;

   logic [PAT_W-1:0] patternReg;
   logic [LEN_W-1:0] lenReg;
   logic [GAP_W-1:0] gapReg;

   logic [LEN_W-1:0] lenClamped;
   logic [REP_W-1:0] repRemainIn;
   logic [LEN_W-1:0] lastIdx;
   logic             accept;

   logic             bitLoad, bitDec, bitZero;
   logic [LEN_W-1:0] bitLoadVal, bitCnt;
   logic             repLoad, repDec, repZero;
   logic [REP_W-1:0] repCnt;
   logic             gapLoad, gapDec, gapZero;
   logic [GAP_W-1:0] gapCnt;

   logic seqNext, validNext, frameNext, busyNext, doneNext;

   function automatic logic bitOf(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] idx);
      logic [PAT_W-1:0] shifted;
      shifted = pat >> idx;
      return shifted[0];
   endfunction

   // Oversized lengths are clamped to the pattern width; the repeat counter
   // holds repetitions remaining after the current one, so 0 and 1 both mean
   // a single repetition.
   always_comb begin
      lenClamped  = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
      repRemainIn = (rep_in == '0) ? '0 : rep_in - REP_W'(1);
      lastIdx     = lenReg - LEN_W'(1);
   end

   manhattan_down_counter #(.W(LEN_W)) bitCounter (
      .clock(clock), .reset(reset), .load(bitLoad), .loadValue(bitLoadVal),
      .decrement(bitDec), .value(bitCnt), .zero(bitZero)
   );

   manhattan_down_counter #(.W(REP_W)) repCounter (
      .clock(clock), .reset(reset), .load(repLoad), .loadValue(repRemainIn),
      .decrement(repDec), .value(repCnt), .zero(repZero)
   );

   manhattan_down_counter #(.W(GAP_W)) gapCounter (
      .clock(clock), .reset(reset), .load(gapLoad), .loadValue(gapReg - GAP_W'(1)),
      .decrement(gapDec), .value(gapCnt), .zero(gapZero)
   );

   // Next-state and next-output decode. Outputs are computed for the cycle
   // after the edge and registered, so the first bit of a frame appears one
   // cycle after start is accepted and nothing reaches the pins combinationally.
   always_comb begin
      stateNext  = state;
      accept     = 1'b0;
      bitLoad    = 1'b0;
      bitLoadVal = lastIdx;
      bitDec     = 1'b0;
      repLoad    = 1'b0;
      repDec     = 1'b0;
      gapLoad    = 1'b0;
      gapDec     = 1'b0;
      seqNext    = 1'b0;
      validNext  = 1'b0;
      frameNext  = 1'b0;
      busyNext   = 1'b0;
      doneNext   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               repLoad = 1'b1;
               if (lenClamped != '0) begin
                  stateNext  = SEND;
                  bitLoad    = 1'b1;
                  bitLoadVal = lenClamped - LEN_W'(1);
                  seqNext    = bitOf(pattern_in, lenClamped - LEN_W'(1));
                  validNext  = 1'b1;
                  frameNext  = 1'b1;
                  busyNext   = 1'b1;
               end else begin
                  stateNext = FIN;
                  doneNext  = 1'b1;
               end
            end
         end
         SEND: begin
            if (!bitZero) begin
               bitDec    = 1'b1;
               seqNext   = bitOf(patternReg, bitCnt - LEN_W'(1));
               validNext = 1'b1;
               busyNext  = 1'b1;
            end else if (!repZero) begin
               repDec   = 1'b1;
               busyNext = 1'b1;
               if (gapReg != '0) begin
                  stateNext = GAP;
                  gapLoad   = 1'b1;
               end else begin
                  bitLoad   = 1'b1;
                  seqNext   = bitOf(patternReg, lastIdx);
                  validNext = 1'b1;
                  frameNext = 1'b1;
               end
            end else begin
               stateNext = FIN;
               doneNext  = 1'b1;
            end
         end
         GAP: begin
            busyNext = 1'b1;
            if (gapZero) begin
               stateNext = SEND;
               bitLoad   = 1'b1;
               seqNext   = bitOf(patternReg, lastIdx);
               validNext = 1'b1;
               frameNext = 1'b1;
            end else begin
               gapDec = 1'b1;
            end
         end
         FIN: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, job parameters and output registers. Reset abandons any frame in
   // flight without a done pulse and restores the power-up pattern.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         patternReg   <= DEFAULT_PATTERN;
         lenReg       <= LEN_W'(DEFAULT_LEN);
         gapReg       <= '0;
         sequence_out <= 1'b0;
         valid_out    <= 1'b0;
         frame_start  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= stateNext;
         sequence_out <= seqNext;
         valid_out    <= validNext;
         frame_start  <= frameNext;
         busy         <= busyNext;
         done         <= doneNext;
         if (accept) begin
            patternReg <= pattern_in;
            lenReg     <= lenClamped;
            gapReg     <= gap_in;
         end
      end
   end

endmodule
